wb_arbiter_bus: RTL

WB_ARBITER_BUS -- requirements
Module: wb_arbiter_bus

---
 rtl/wb_bus_pkg.sv | 15 +
 rtl/wb_rr_arbiter.sv | 35 +++
 rtl/wb_arbiter_bus.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_pkg.sv
// Shared types and constants for the Wishbone arbiter/bus.
// Holds the arbiter FSM state enum, bus widths and the timeout counter width.
package wb_bus_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int WB_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin request -> one-hot grant, starting after the last-granted index.
// Ports: req_i (requests), last_i (last-granted index), gnt_o (one-hot), idx_o.
module wb_rr_arbiter
  import wb_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   last_i,
  output logic [N-1:0] gnt_o,
  output logic [2:0]   idx_o
);

  logic [N-1:0] hi;
  logic [N-1:0] pick;

  // Requests above the last grant win; otherwise wrap to the lowest.
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) begin
      hi[i] = req_i[i] && (i > int'(last_i));
    end
    pick  = (|hi) ? hi : req_i;
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_bus.sv
// Wishbone N-master / N-slave shared bus: round-robin arbiter, address
// decode, slave/master muxing, unmapped-address error.
// Ports: sys_clk/sys_rst, m_* master side, s_* slave side, gnt_o debug.
// Optional stalled-access timeout: define WB_ARBITER_BUS_TIMEOUT_EN.
module wb_arbiter_bus
  import wb_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 6,
  parameter int DEC_W     = 3,
  parameter logic [N_SLAVES*DEC_W-1:0] SLAVE_ADDR =
    {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [N_MASTERS*WB_DAT_W-1:0] m_adr_i,
  input  logic [N_MASTERS*WB_DAT_W-1:0] m_dat_i,
  input  logic [N_MASTERS*WB_SEL_W-1:0] m_sel_i,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS-1:0]          m_cyc_i,
  input  logic [N_MASTERS-1:0]          m_stb_i,
  output logic [WB_DAT_W-1:0]           m_dat_o,
  output logic [N_MASTERS-1:0]          m_ack_o,
  output logic [N_MASTERS-1:0]          m_err_o,
  output logic [WB_DAT_W-1:0]           s_adr_o,
  output logic [WB_DAT_W-1:0]           s_dat_o,
  output logic [WB_SEL_W-1:0]           s_sel_o,
  output logic                          s_we_o,
  output logic [N_SLAVES-1:0]           s_cyc_o,
  output logic [N_SLAVES-1:0]           s_stb_o,
  input  logic [N_SLAVES*WB_DAT_W-1:0]  s_dat_i,
  input  logic [N_SLAVES-1:0]           s_ack_i,
  output logic [N_MASTERS-1:0]          gnt_o
);

  state_e state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [2:0] last_q, last_d;

  logic [N_MASTERS-1:0] arb_gnt;
  logic [2:0] arb_idx;

  logic [WB_DAT_W-1:0] g_adr, g_dat, dat_sel;
  logic [WB_SEL_W-1:0] g_sel;
  logic g_we, g_cyc, g_stb;
  logic [N_SLAVES-1:0] sel_oh;
  logic hit, ack_sel, busy, to_hit;

  wb_rr_arbiter #(.N(N_MASTERS)) u_arb (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt_q[i]) begin
        g_adr = m_adr_i[i*WB_DAT_W +: WB_DAT_W];
        g_dat = m_dat_i[i*WB_DAT_W +: WB_DAT_W];
        g_sel = m_sel_i[i*WB_SEL_W +: WB_SEL_W];
        g_we  = m_we_i[i];
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
      end
    end
  end

  // Descending scan so the lowest matching slave wins.
  always_comb begin
    sel_oh  = '0;
    dat_sel = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (g_adr[WB_DAT_W-1:WB_DAT_W-DEC_W] ==
          SLAVE_ADDR[k*DEC_W +: DEC_W]) begin
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        dat_sel   = s_dat_i[k*WB_DAT_W +: WB_DAT_W];
      end
    end
  end

  assign hit     = |sel_oh;
  assign ack_sel = |(s_ack_i & sel_oh);
  assign busy    = (state_q == BUSY);

  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;
  assign s_cyc_o = (busy && g_cyc) ? sel_oh : '0;
  assign s_stb_o = (busy && g_stb) ? sel_oh : '0;

  // Gating by the live cyc drops an ack that races a cyc release.
  assign m_ack_o = (busy && ack_sel) ? (gnt_q & m_cyc_i) : '0;
  assign m_err_o = (state_q == ERR) ? (gnt_q & m_cyc_i) : '0;
  assign m_dat_o = (busy && hit) ? dat_sel : '0;
  assign gnt_o   = gnt_q;

`ifdef WB_ARBITER_BUS_TIMEOUT_EN
  logic [WB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    to_hit = 1'b0;
    if (busy && g_cyc && g_stb && !ack_sel) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == WB_CNT_W'(TIMEOUT_CYC)) begin
        to_hit = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = BUSY;
          gnt_d   = arb_gnt;
          last_d  = arb_idx;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if ((g_stb && !hit) || to_hit) begin
          state_d = ERR;
        end
      end
      ERR: begin
        if (g_cyc) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 3'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule
